// File: rtl/cache_mem_ctrl.sv
// rtl/cache_mem_ctrl.sv - arbitrated instruction/data access controller for a single RAM port
module cache_mem_ctrl #(
  parameter int          MAX_WAIT = 16,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr,
  output logic [15:0] icount,
  output logic [15:0] dcount
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          last_data_q, last_data_d;
  logic          memerr_q, memerr_d;
  logic [15:0]   icount_q, icount_d;
  logic [15:0]   dcount_q, dcount_d;

  logic        d_req;
  logic        ram_ok;
  logic        complete;
  logic        failed;
  logic [31:0] done_word;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      last_data_q <= 1'b0;
      memerr_q    <= 1'b0;
      icount_q    <= '0;
      dcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      last_data_q <= last_data_d;
      memerr_q    <= memerr_d;
      icount_q    <= icount_d;
      dcount_q    <= dcount_d;
    end
  end

  // A RAM ACCESS wins over a coincident timeout; ERROR or timeout returns ERR_WORD.
  always_comb begin
    d_req     = dREN | dWEN;
    ram_ok    = (ramstate == 2'd2);
    complete  = ram_ok || (ramstate == 2'd3) || (wait_cnt_q == CW'(MAX_WAIT));
    failed    = complete && !ram_ok;
    done_word = ram_ok ? ramload : ERR_WORD;
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    last_data_d = last_data_q;
    memerr_d    = memerr_q;
    icount_d    = icount_q;
    dcount_d    = dcount_q;
    iwait       = 1'b1;
    iload       = '0;
    dwait       = 1'b1;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (d_req && iREN)  state_d = last_data_q ? I_ACC : D_ACC;
        else if (d_req)     state_d = D_ACC;
        else if (iREN)      state_d = I_ACC;
      end

      D_ACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (complete) begin
          dwait       = 1'b0;
          dload       = done_word;
          dcount_d    = (dcount_q == 16'hFFFF) ? dcount_q : dcount_q + 16'd1;
          memerr_d    = memerr_q | failed;
          last_data_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      I_ACC: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (!iREN) begin
          state_d = IDLE;
        end else if (complete) begin
          iwait       = 1'b0;
          iload       = done_word;
          icount_d    = (icount_q == 16'hFFFF) ? icount_q : icount_q + 16'd1;
          memerr_d    = memerr_q | failed;
          last_data_d = 1'b0;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign memerr = memerr_q;
  assign icount = icount_q;
  assign dcount = dcount_q;

endmodule
